deserializador: RTL and testbench

DESERIALIZADOR -- requirements
Module: deserializador

---
 rtl/deserializador_pkg.sv | 12 +
 rtl/deserializador_shift_reg.sv | 51 +++++
 rtl/deserializador.sv | 88 ++++++++
 tb/tb_deserializador.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/deserializador_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package deserializador_pkg;

    // Bits per word unless the instantiating level overrides it.
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        RECEIVE  = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

endpackage

// File: rtl/deserializador_shift_reg.sv
// Shift register and bit counter for one serial word, MSB first.
// word_o is the value the register takes on this edge, so the top can
// capture the full word on the same edge that samples the last bit.
module deserializador_shift_reg
    import deserializador_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  shift_en_i,
    input  logic                  data_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  done_o
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Shift in a bit when enabled; wrap the counter and flag completion on the last bit.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        word_o  = {shift_q[DATA_WIDTH-2:0], data_i};
        if (shift_en_i) begin
            shift_d = word_o;
            if (cnt_q == LAST_BIT) begin
                cnt_d  = '0;
                done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register the shift contents and bit count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver with a ready/ack handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RECEIVE  | accepting qualified serial bits, ack_in ignored
//   WAIT_ACK | completed word held on data_out, bits refused until ack_in
//
// When ack_in and write_in coincide in WAIT_ACK the bit is dropped: the
// shifter is only enabled in RECEIVE.
module deserializador
    import deserializador_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_100KHz,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  ack_in,
    output logic                  status_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_ready
);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  shift_en;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word_next;

    deserializador_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_reg (
        .clk_i      (clk_100KHz),
        .rst_i      (reset),
        .shift_en_i (shift_en),
        .data_i     (data_in),
        .word_o     (word_next),
        .done_o     (word_done)
    );

    // Next-state, shift enable and output-register loads.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        data_out_d = data_out_q;
        shift_en   = 1'b0;
        case (state_q)
            RECEIVE: begin
                shift_en = write_in;
                if (word_done) begin
                    state_d    = WAIT_ACK;
                    ready_d    = 1'b1;
                    data_out_d = word_next;
                end
            end
            WAIT_ACK: begin
                if (ack_in) begin
                    state_d = RECEIVE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = RECEIVE;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state_q    <= RECEIVE;
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_ready = ready_q;
    assign status_out = ready_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed self-checking bench for deserializador.
module tb_deserializador;

    localparam int W = 8;

    logic         clk_100KHz = 1'b0;
    logic         reset      = 1'b1;
    logic         data_in    = 1'b0;
    logic         write_in   = 1'b0;
    logic         ack_in     = 1'b0;
    logic         status_out;
    logic [W-1:0] data_out;
    logic         data_ready;

    int checks = 0;
    int errors = 0;

    deserializador #(.DATA_WIDTH(W)) dut (
        .clk_100KHz (clk_100KHz),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (ack_in),
        .status_out (status_out),
        .data_out   (data_out),
        .data_ready (data_ready)
    );

    always #5 clk_100KHz = ~clk_100KHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ready and status must match each other and the expected level.
    task automatic check_ready(input string tag, input logic exp);
        check({tag, "_ready"}, {31'd0, data_ready}, {31'd0, exp});
        check({tag, "_status"}, {31'd0, status_out}, {31'd0, exp});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_100KHz);
    endtask

    // One bit held for one cycle, then `gap` idle cycles.
    task automatic send_bit(input logic b, input int gap);
        @(negedge clk_100KHz);
        data_in  = b;
        write_in = 1'b1;
        @(negedge clk_100KHz);
        write_in = 1'b0;
        data_in  = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic pulse_ack();
        @(negedge clk_100KHz);
        ack_in = 1'b1;
        @(negedge clk_100KHz);
        ack_in = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pat;

        // Reset state
        idle(2);
        check("rst_data", {24'd0, data_out}, 32'h0);
        check_ready("rst", 1'b0);
        reset = 1'b0;
        idle(1);

        // 1,0,1,0,1,1,0,1 with one idle cycle after each bit -> 0xAD
        pat = 8'hAD;
        for (int i = W - 1; i >= 1; i--) send_bit(pat[i], 1);
        check_ready("ad_before_last", 1'b0);
        send_bit(pat[0], 0);
        check_ready("ad_done", 1'b1);
        check("ad_data", {24'd0, data_out}, 32'hAD);
        pulse_ack();
        check_ready("ad_acked", 1'b0);
        check("ad_hold_after_ack", {24'd0, data_out}, 32'hAD);

        // Bits refused while a word is pending
        send_word(8'hAD, 0);
        check_ready("ad2_done", 1'b1);
        send_word(8'h00, 0);
        check("refused_data", {24'd0, data_out}, 32'hAD);
        check_ready("refused", 1'b1);
        pulse_ack();
        // ack in RECEIVE mid-word must be ignored
        pat = 8'h3C;
        for (int i = W - 1; i >= 4; i--) send_bit(pat[i], 0);
        pulse_ack();
        for (int i = 3; i >= 0; i--) send_bit(pat[i], 0);
        check_ready("3c_done", 1'b1);
        check("3c_data", {24'd0, data_out}, 32'h3C);
        pulse_ack();

        // 0xFF with 0..5 idle cycles between bits
        for (int i = 0; i < W; i++) begin
            send_bit(1'b1, i % 6);
            check({"ff_bit", string'(8'h30 + 8'(i))}, {31'd0, data_ready}, {31'd0, (i == W - 1)});
        end
        check("ff_data", {24'd0, data_out}, 32'hFF);
        pulse_ack();

        // Asynchronous reset mid-word, then 0x81
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        @(posedge clk_100KHz);
        #2 reset = 1'b1;
        #1;
        check("async_rst_data", {24'd0, data_out}, 32'h0);
        check_ready("async_rst", 1'b0);
        @(negedge clk_100KHz);
        reset = 1'b0;
        send_word(8'h81, 0);
        check_ready("81_done", 1'b1);
        check("81_data", {24'd0, data_out}, 32'h81);

        // Reset while a word is pending drops it without ack
        @(negedge clk_100KHz);
        reset = 1'b1;
        #1;
        check_ready("rst_wait", 1'b0);
        @(negedge clk_100KHz);
        reset = 1'b0;
        send_word(8'h42, 0);
        check("42_data", {24'd0, data_out}, 32'h42);

        // ack and write together in WAIT_ACK: ack wins, bit discarded
        @(negedge clk_100KHz);
        ack_in   = 1'b1;
        write_in = 1'b1;
        data_in  = 1'b1;
        @(negedge clk_100KHz);
        ack_in   = 1'b0;
        write_in = 1'b0;
        data_in  = 1'b0;
        check_ready("coinc_acked", 1'b0);
        pat = 8'h5A;
        for (int i = W - 1; i >= 1; i--) send_bit(pat[i], 0);
        check_ready("5a_before_last", 1'b0);
        send_bit(pat[0], 0);
        check_ready("5a_done", 1'b1);
        check("5a_data", {24'd0, data_out}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
